usb_rx_packet_controller: RTL and testbench
===========================================

Name: usb_rx_packet_controller

Overview:
- Sequences the USB receive path.
- Consumes the decoded byte stream from the serial front end (NRZI/bit-unstuff/sync stage) and validates each packet's PID and CRC.
- Filters tokens by device address.
- Writes accepted DATA0/DATA1 payloads into the shared packet buffer, then holds that buffer for the CPU with a ready/ack handshake until software releases it.

Parameters:
- BUFFER_BYTES, 1024, packet buffer capacity in bytes; max accepted payload incl. 2 CRC bytes.
- ADDR_W, $clog2(BUFFER_BYTES), buffer byte-address width.

Ports:
- clock48  input  1  48 MHz system clock.
- reset_n  input  1  asynchronous active-low reset.
- rx_byte  input  8  received byte, LSB = first bit on wire.
- rx_byte_valid  input  1  one-cycle strobe, rx_byte valid.
- rx_eop  input  1  one-cycle strobe, end of packet seen; never coincident with rx_byte_valid.
- rx_error  input  1  one-cycle strobe, bit-stuff/sync error in current packet.
- device_address  input  7  current USB address, sampled at token check.
- buf_we  output  1  buffer write enable.
- buf_addr  output  ADDR_W  buffer write byte address.
- buf_wdata  output  8  buffer write data.
- packet_ready  output  1  accepted data packet held in buffer.
- packet_pid  output  4  PID of held packet (4'b0011 DATA0, 4'b1011 DATA1).
- packet_endpoint  output  4  endpoint from the preceding matching token.
- packet_setup  output  1  preceding token was SETUP (1) or OUT (0).
- packet_length  output  ADDR_W+1  payload bytes, excluding CRC16.
- packet_ack  input  1  CPU releases buffer; one-cycle strobe.
- overflow_count  output  8  saturating count of packets dropped while the buffer was held or too long.

Behaviour:
- Reset values: all outputs 0, state IDLE, token_match flag 0. Reset mid-packet discards the packet immediately.
- States:
  - IDLE: first rx_byte_valid goes to PID_CHECK with that byte.
  - PID_CHECK (same cycle as byte capture): valid iff rx_byte[7:4] == ~rx_byte[3:0]. Invalid PID goes to DISCARD.
    - OUT(0001)/SETUP(1101): go to TOKEN.
    - DATA0/DATA1: go to DATA if token_match=1 and packet_ready=0; otherwise DISCARD and increment overflow_count only if token_match=1.
    - Any other valid PID: clear token_match, go to DISCARD.
  - TOKEN: collect exactly 2 bytes, then require rx_eop.
    - On EOP, CRC5 over the 11 bits must leave residual 5'b01100 and addr == device_address. Then set token_match=1 and latch endpoint and setup; otherwise clear token_match.
    - A third byte or EOP after <2 bytes clears token_match and goes to DISCARD/IDLE.
  - DATA: each byte is written at buf_addr = byte_index, starting at 0, with buf_we high for one cycle in the cycle after rx_byte_valid. CRC16 runs over all bytes. Byte_index reaching BUFFER_BYTES is overflow: go to DISCARD and increment overflow_count.
    - On rx_eop with byte_index >= 2 and CRC16 residual 16'h800D (x^15..x^0 order): packet_ready=1 the next cycle, packet_length = byte_index-2, latch PID. Clear token_match in all cases.
    - Bad CRC or <2 bytes: drop silently; packet_ready stays 0.
  - DISCARD: ignore bytes until rx_eop, then IDLE.
  - rx_error in any non-IDLE state goes to DISCARD and clears token_match.
- Handshake:
  - packet_ready stays high and the packet_* outputs stay stable until packet_ack.
  - packet_ack clears packet_ready the next cycle.
  - packet_ack while packet_ready=0 is ignored.
  - packet_ack in the same cycle a new DATA PID arrives: the new packet is still dropped, because the held check uses the registered packet_ready.
- Buffer is never written while packet_ready=1.
- overflow_count saturates at 255.
- CRC registers are initialised to all-ones at PID; LSB-first shift per USB 2.0 §8.3.5.

Test Plan:
- Bytes 2D 00 10, EOP, device_address=0; then C3 80 06 00 01 00 00 40 00 DD 94, EOP -> buffer[0..9] = 80 06 00 01 00 00 40 00 DD 94, packet_ready=1, packet_pid=0011, packet_setup=1, packet_endpoint=0, packet_length=8.
- Same token with device_address=5 -> token_match=0, data packet discarded, no buf_we, packet_ready=0, overflow_count=0.
- Valid SETUP+DATA0 while packet_ready=1 -> no buf_we, held outputs unchanged, overflow_count=1; packet_ack -> packet_ready=0 next cycle.
- DATA packet with last byte 94 changed to 95 -> bytes written, packet_ready stays 0; following DATA0 without a new token is discarded.
- PID byte 2C (nibble mismatch) -> DISCARD until EOP, token_match unchanged, next valid token is accepted normally.
- rx_error mid-DATA, and reset_n pulsed low mid-DATA -> no packet_ready, state IDLE, all outputs 0 after reset.

Source files
------------

// File: rtl/usb_rx_packet_controller.sv
// USB receive packet controller.
// Consumes the decoded byte stream from the serial front end. It checks the PID,
// checks the token CRC5 and address, and writes accepted DATA0/DATA1 payloads
// into the shared packet buffer. The buffer is then held for the CPU until
// software releases it with packet_ack.
`timescale 1ns/1ps
module usb_rx_packet_controller #(
    parameter int BUFFER_BYTES = 1024,
    parameter int ADDR_W       = $clog2(BUFFER_BYTES)
) (
    input  logic              clock48,
    input  logic              reset_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_byte_valid,
    input  logic              rx_eop,
    input  logic              rx_error,
    input  logic [6:0]        device_address,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              packet_ready,
    output logic [3:0]        packet_pid,
    output logic [3:0]        packet_endpoint,
    output logic              packet_setup,
    output logic [ADDR_W:0]   packet_length,
    input  logic              packet_ack,
    output logic [7:0]        overflow_count
);

    localparam logic [3:0]      PID_OUT        = 4'b0001;
    localparam logic [3:0]      PID_SETUP      = 4'b1101;
    localparam logic [3:0]      PID_DATA0      = 4'b0011;
    localparam logic [3:0]      PID_DATA1      = 4'b1011;
    localparam logic [4:0]      CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0]     CRC16_RESIDUAL = 16'h800D;
    localparam logic [ADDR_W:0] IDX_LIMIT      = (ADDR_W+1)'(BUFFER_BYTES);
    localparam logic [ADDR_W:0] IDX_TWO        = (ADDR_W+1)'(2);

    // The PID check happens in the same cycle the PID byte is taken in IDLE,
    // so it needs no state of its own.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TOKEN   = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic              token_match_r, token_match_s;
    logic [1:0]        tok_cnt_r, tok_cnt_s;
    logic [7:0]        tok_byte0_r, tok_byte0_s;
    logic [2:0]        tok_endp_hi_r, tok_endp_hi_s;
    logic [3:0]        tok_endp_r, tok_endp_s;
    logic              tok_setup_r, tok_setup_s;
    logic [3:0]        pid_r, pid_s;
    logic [4:0]        crc5_r, crc5_s;
    logic [15:0]       crc16_r, crc16_s;
    logic [ADDR_W:0]   byte_index_r, byte_index_s;
    logic              buf_we_r, buf_we_s;
    logic [ADDR_W-1:0] buf_addr_r, buf_addr_s;
    logic [7:0]        buf_wdata_r, buf_wdata_s;
    logic              packet_ready_r, packet_ready_s;
    logic [3:0]        packet_pid_r, packet_pid_s;
    logic [3:0]        packet_endpoint_r, packet_endpoint_s;
    logic              packet_setup_r, packet_setup_s;
    logic [ADDR_W:0]   packet_length_r, packet_length_s;
    logic [7:0]        overflow_r, overflow_s;

    // CRC5 (x^5+x^2+1) advanced by one byte, LSB first on the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] data);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ data[i];
            c  = {c[3:0], 1'b0};
            if (fb) c = c ^ 5'b00101;
            else    c = c;
        end
        return c;
    endfunction

    // CRC16 (x^16+x^15+x^2+1) advanced by one byte, LSB first on the wire.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
            else    c = c;
        end
        return c;
    endfunction

    // The PID check field is the ones-complement of the PID.
    function automatic logic pid_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

    // Increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) return v;
        else            return v + 8'h01;
    endfunction

    // Next-state and next-output logic for the receive sequencer.
    always_comb begin
        state_s           = state_r;
        token_match_s     = token_match_r;
        tok_cnt_s         = tok_cnt_r;
        tok_byte0_s       = tok_byte0_r;
        tok_endp_hi_s     = tok_endp_hi_r;
        tok_endp_s        = tok_endp_r;
        tok_setup_s       = tok_setup_r;
        pid_s             = pid_r;
        crc5_s            = crc5_r;
        crc16_s           = crc16_r;
        byte_index_s      = byte_index_r;
        buf_we_s          = 1'b0;
        buf_addr_s        = buf_addr_r;
        buf_wdata_s       = buf_wdata_r;
        packet_pid_s      = packet_pid_r;
        packet_endpoint_s = packet_endpoint_r;
        packet_setup_s    = packet_setup_r;
        packet_length_s   = packet_length_r;
        overflow_s        = overflow_r;

        // An acknowledge releases a held buffer. An acknowledge with no held
        // packet is ignored.
        if (packet_ack && packet_ready_r) packet_ready_s = 1'b0;
        else                              packet_ready_s = packet_ready_r;

        case (state_r)
            ST_IDLE: begin
                if (rx_byte_valid) begin
                    pid_s        = rx_byte[3:0];
                    crc5_s       = 5'h1F;
                    crc16_s      = 16'hFFFF;
                    tok_cnt_s    = 2'd0;
                    byte_index_s = '0;
                    if (!pid_ok(rx_byte)) begin
                        state_s = ST_DISCARD;
                    end else begin
                        case (rx_byte[3:0])
                            PID_OUT, PID_SETUP: begin
                                state_s = ST_TOKEN;
                            end
                            PID_DATA0, PID_DATA1: begin
                                // The held check uses the registered ready, so an
                                // ack in this same cycle does not admit the packet.
                                if (token_match_r && !packet_ready_r) begin
                                    state_s = ST_DATA;
                                end else begin
                                    state_s = ST_DISCARD;
                                    if (token_match_r) overflow_s = sat_inc8(overflow_r);
                                    else               overflow_s = overflow_r;
                                end
                            end
                            default: begin
                                token_match_s = 1'b0;
                                state_s       = ST_DISCARD;
                            end
                        endcase
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_TOKEN: begin
                if (rx_error) begin
                    token_match_s = 1'b0;
                    state_s       = ST_DISCARD;
                end else if (rx_byte_valid) begin
                    if (tok_cnt_r == 2'd2) begin
                        token_match_s = 1'b0;
                        state_s       = ST_DISCARD;
                    end else begin
                        crc5_s    = crc5_byte(crc5_r, rx_byte);
                        tok_cnt_s = tok_cnt_r + 2'd1;
                        if (tok_cnt_r == 2'd0) tok_byte0_s   = rx_byte;
                        else                   tok_endp_hi_s = rx_byte[2:0];
                    end
                end else if (rx_eop) begin
                    state_s = ST_IDLE;
                    if ((tok_cnt_r == 2'd2) && (crc5_r == CRC5_RESIDUAL) &&
                        (tok_byte0_r[6:0] == device_address)) begin
                        token_match_s = 1'b1;
                        tok_endp_s    = {tok_endp_hi_r, tok_byte0_r[7]};
                        tok_setup_s   = (pid_r == PID_SETUP);
                    end else begin
                        token_match_s = 1'b0;
                    end
                end else begin
                    state_s = ST_TOKEN;
                end
            end

            ST_DATA: begin
                if (rx_error) begin
                    token_match_s = 1'b0;
                    state_s       = ST_DISCARD;
                end else if (rx_byte_valid) begin
                    if (byte_index_r == IDX_LIMIT) begin
                        // Payload longer than the buffer.
                        token_match_s = 1'b0;
                        overflow_s    = sat_inc8(overflow_r);
                        state_s       = ST_DISCARD;
                    end else begin
                        buf_we_s     = 1'b1;
                        buf_addr_s   = byte_index_r[ADDR_W-1:0];
                        buf_wdata_s  = rx_byte;
                        crc16_s      = crc16_byte(crc16_r, rx_byte);
                        byte_index_s = byte_index_r + (ADDR_W+1)'(1);
                    end
                end else if (rx_eop) begin
                    token_match_s = 1'b0;
                    state_s       = ST_IDLE;
                    if ((byte_index_r >= IDX_TWO) && (crc16_r == CRC16_RESIDUAL)) begin
                        packet_ready_s    = 1'b1;
                        packet_length_s   = byte_index_r - IDX_TWO;
                        packet_pid_s      = pid_r;
                        packet_endpoint_s = tok_endp_r;
                        packet_setup_s    = tok_setup_r;
                    end else begin
                        packet_ready_s = packet_ready_r;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end

            ST_DISCARD: begin
                if (rx_error) token_match_s = 1'b0;
                else          token_match_s = token_match_r;
                if (rx_eop) state_s = ST_IDLE;
                else        state_s = ST_DISCARD;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers. A reset in the middle of a packet drops the packet.
    always_ff @(posedge clock48 or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= ST_IDLE;
            token_match_r     <= 1'b0;
            tok_cnt_r         <= 2'd0;
            tok_byte0_r       <= 8'h00;
            tok_endp_hi_r     <= 3'd0;
            tok_endp_r        <= 4'd0;
            tok_setup_r       <= 1'b0;
            pid_r             <= 4'd0;
            crc5_r            <= 5'd0;
            crc16_r           <= 16'h0000;
            byte_index_r      <= '0;
            buf_we_r          <= 1'b0;
            buf_addr_r        <= '0;
            buf_wdata_r       <= 8'h00;
            packet_ready_r    <= 1'b0;
            packet_pid_r      <= 4'd0;
            packet_endpoint_r <= 4'd0;
            packet_setup_r    <= 1'b0;
            packet_length_r   <= '0;
            overflow_r        <= 8'h00;
        end else begin
            state_r           <= state_s;
            token_match_r     <= token_match_s;
            tok_cnt_r         <= tok_cnt_s;
            tok_byte0_r       <= tok_byte0_s;
            tok_endp_hi_r     <= tok_endp_hi_s;
            tok_endp_r        <= tok_endp_s;
            tok_setup_r       <= tok_setup_s;
            pid_r             <= pid_s;
            crc5_r            <= crc5_s;
            crc16_r           <= crc16_s;
            byte_index_r      <= byte_index_s;
            buf_we_r          <= buf_we_s;
            buf_addr_r        <= buf_addr_s;
            buf_wdata_r       <= buf_wdata_s;
            packet_ready_r    <= packet_ready_s;
            packet_pid_r      <= packet_pid_s;
            packet_endpoint_r <= packet_endpoint_s;
            packet_setup_r    <= packet_setup_s;
            packet_length_r   <= packet_length_s;
            overflow_r        <= overflow_s;
        end
    end

    assign buf_we          = buf_we_r;
    assign buf_addr        = buf_addr_r;
    assign buf_wdata       = buf_wdata_r;
    assign packet_ready    = packet_ready_r;
    assign packet_pid      = packet_pid_r;
    assign packet_endpoint = packet_endpoint_r;
    assign packet_setup    = packet_setup_r;
    assign packet_length   = packet_length_r;
    assign overflow_count  = overflow_r;

endmodule

// File: tb/tb_usb_rx_packet_controller.sv
// Self-checking bench for usb_rx_packet_controller. A packet-level model predicts
// buffer writes, held-packet outputs and the drop counter. These predictions are
// compared on every falling clock edge.
`timescale 1ns/1ps
module tb_usb_rx_packet_controller;

    localparam int BB = 1024;
    localparam int AW = 10;

    logic          clock48 = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_byte_valid = 1'b0;
    logic          rx_eop = 1'b0;
    logic          rx_error = 1'b0;
    logic [6:0]    device_address = 7'd0;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic          packet_ready;
    logic [3:0]    packet_pid;
    logic [3:0]    packet_endpoint;
    logic          packet_setup;
    logic [AW:0]   packet_length;
    logic          packet_ack = 1'b0;
    logic [7:0]    overflow_count;

    usb_rx_packet_controller #(.BUFFER_BYTES(BB)) dut (
        .clock48(clock48), .reset_n(reset_n), .rx_byte(rx_byte),
        .rx_byte_valid(rx_byte_valid), .rx_eop(rx_eop), .rx_error(rx_error),
        .device_address(device_address), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .packet_ready(packet_ready), .packet_pid(packet_pid),
        .packet_endpoint(packet_endpoint), .packet_setup(packet_setup),
        .packet_length(packet_length), .packet_ack(packet_ack),
        .overflow_count(overflow_count)
    );

    always #5 clock48 = ~clock48;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    bit         m_match = 0, m_ready = 0, m_setup = 0, m_tok_setup = 0;
    logic [3:0] m_pid = 0, m_endp = 0, m_tok_endp = 0;
    int         m_len = 0, m_ovf = 0;
    int         q_addr[$];
    logic [7:0] q_data[$];

    logic [7:0] pkt[$];
    logic [7:0] pay[$];
    bit         bq[$];
    logic [7:0] cap_mem [0:BB-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_byte_bits(input logic [7:0] b);
        for (int k = 0; k < 8; k++) bq.push_back(b[k]);
    endfunction

    // Generic bit-serial CRC over bq, register preset to all ones.
    function automatic int crc_bq(input int w, input int poly);
        int r, mask, msb;
        r = (1 << w) - 1;
        mask = r;
        foreach (bq[i]) begin
            msb = (r >> (w - 1)) & 1;
            r = (r << 1) & mask;
            if ((msb ^ int'(bq[i])) == 1) r = r ^ poly;
        end
        return r;
    endfunction

    task automatic pack_bq();
        logic [7:0] b;
        for (int i = 0; i < bq.size() / 8; i++) begin
            for (int k = 0; k < 8; k++) b[k] = bq[i*8+k];
            pkt.push_back(b);
        end
    endtask

    task automatic build_token(input logic [3:0] pid4, input logic [6:0] addr, input logic [3:0] endp);
        int r;
        pkt.delete();
        pkt.push_back({~pid4, pid4});
        bq.delete();
        for (int k = 0; k < 7; k++) bq.push_back(addr[k]);
        for (int k = 0; k < 4; k++) bq.push_back(endp[k]);
        r = crc_bq(5, 'h05);
        for (int j = 4; j >= 0; j--) bq.push_back(((r >> j) & 1) == 0);
        pack_bq();
    endtask

    task automatic build_data(input logic [3:0] pid4);
        int r;
        pkt.delete();
        pkt.push_back({~pid4, pid4});
        bq.delete();
        foreach (pay[i]) begin
            pkt.push_back(pay[i]);
            add_byte_bits(pay[i]);
        end
        r = crc_bq(16, 'h8005);
        bq.delete();
        for (int j = 15; j >= 0; j--) bq.push_back(((r >> j) & 1) == 0);
        pack_bq();
    endtask

    task automatic fill_pay(input int n, input int seed);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(seed + i * 37));
    endtask

    task automatic tick();
        @(posedge clock48);
        #1;
    endtask

    // Send pkt. Optional events: rx_error before EOP, a reset instead of EOP,
    // or packet_ack in the same cycle as the PID.
    task automatic send_packet(input bit err, input bit rst, input bit ack_pid);
        logic [7:0] p;
        logic [3:0] tok_endp;
        int nb, ovf_at, cnt, r;
        bit new_match, acc, ovfd, tok_ok;
        p = pkt[0]; nb = pkt.size(); new_match = m_match; ovf_at = -1;
        acc = 0; cnt = 0; ovfd = 0; tok_ok = 0; tok_endp = 4'd0;
        if (p[7:4] == ~p[3:0]) begin
            if (p[3:0] == 4'b0001 || p[3:0] == 4'b1101) begin
                new_match = 0;
                if (nb == 3) begin
                    bq.delete(); add_byte_bits(pkt[1]); add_byte_bits(pkt[2]);
                    r = crc_bq(5, 'h05);
                    if (r == 'h0C && pkt[1][6:0] == device_address) begin
                        new_match = 1; tok_ok = 1; tok_endp = {pkt[2][2:0], pkt[1][7]};
                    end
                end
            end else if (p[3:0] == 4'b0011 || p[3:0] == 4'b1011) begin
                if (m_match && !m_ready) begin
                    new_match = 0;
                    for (int i = 1; i < nb && !ovfd; i++) begin
                        if (cnt == BB) begin
                            ovf_at = i; ovfd = 1;
                        end else begin
                            q_addr.push_back(cnt); q_data.push_back(pkt[i]); cnt++;
                        end
                    end
                    if (!ovfd && cnt >= 2) begin
                        bq.delete();
                        for (int i = 1; i < nb; i++) add_byte_bits(pkt[i]);
                        acc = (crc_bq(16, 'h8005) == 'h800D);
                    end
                end else if (m_match) begin
                    ovf_at = 0;
                end
            end else begin
                new_match = 0;
            end
        end
        if (err) begin new_match = 0; acc = 0; tok_ok = 0; end

        for (int i = 0; i < nb; i++) begin
            rx_byte = pkt[i]; rx_byte_valid = 1'b1;
            if (i == 0 && ack_pid) packet_ack = 1'b1;
            tick();
            rx_byte_valid = 1'b0; packet_ack = 1'b0;
            if (i == ovf_at && m_ovf < 255) m_ovf++;
            if (i == 0 && ack_pid) m_ready = 0;
        end
        if (rst) begin
            @(negedge clock48); #1;
            reset_n = 1'b0;
            m_match = 0; m_ready = 0; m_setup = 0; m_tok_setup = 0;
            m_pid = 0; m_endp = 0; m_tok_endp = 0; m_len = 0; m_ovf = 0;
            tick(); tick();
            reset_n = 1'b1;
            tick();
            chk("writes_after_reset", 32'(q_addr.size()), 32'd0);
            return;
        end
        if (err) begin
            rx_error = 1'b1; tick(); rx_error = 1'b0;
        end
        rx_eop = 1'b1; tick(); rx_eop = 1'b0;
        m_match = new_match;
        if (tok_ok) begin m_tok_endp = tok_endp; m_tok_setup = (p[3:0] == 4'b1101); end
        if (acc) begin
            m_ready = 1; m_pid = p[3:0]; m_endp = m_tok_endp; m_setup = m_tok_setup; m_len = cnt - 2;
        end
        @(negedge clock48); #1;
        chk("pending_writes", 32'(q_addr.size()), 32'd0);
    endtask

    task automatic do_ack();
        packet_ack = 1'b1; tick(); packet_ack = 1'b0;
        m_ready = 0;
    endtask

    task automatic token_to(input logic [3:0] pid4, input logic [6:0] addr, input logic [3:0] endp);
        build_token(pid4, addr, endp);
        send_packet(0, 0, 0);
    endtask

    // Compare process: DUT against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clock48);
            chk("packet_ready", 32'(packet_ready), 32'(m_ready));
            chk("packet_pid", 32'(packet_pid), 32'(m_pid));
            chk("packet_endpoint", 32'(packet_endpoint), 32'(m_endp));
            chk("packet_setup", 32'(packet_setup), 32'(m_setup));
            chk("packet_length", 32'(packet_length), 32'(m_len));
            chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
            if (buf_we) begin
                cap_mem[buf_addr] = buf_wdata;
                chk("write_expected", 32'(q_addr.size() != 0), 32'd1);
                if (q_addr.size() != 0) begin
                    chk("buf_addr", 32'(buf_addr), 32'(q_addr.pop_front()));
                    chk("buf_wdata", 32'(buf_wdata), 32'(q_data.pop_front()));
                end
            end
        end
    end

    logic [7:0] setup_bytes[$];

    initial begin
        setup_bytes = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        tick(); tick();
        chk("reset_ready", 32'(packet_ready), 32'd0);
        chk("reset_buf_we", 32'(buf_we), 32'd0);
        reset_n = 1'b1;
        tick();

        // Pin the generators against known wire values.
        build_token(4'b1101, 7'd0, 4'd0);
        chk("gen_token_b1", 32'(pkt[1]), 32'h00);
        chk("gen_token_b2", 32'(pkt[2]), 32'h10);
        pay = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        build_data(4'b0011);
        chk("gen_crc_lo", 32'(pkt[9]), 32'hDD);
        chk("gen_crc_hi", 32'(pkt[10]), 32'h94);

        // SETUP + DATA0 to address 0 is accepted.
        device_address = 7'd0;
        pkt = '{8'h2D, 8'h00, 8'h10}; send_packet(0, 0, 0);
        pkt = setup_bytes; send_packet(0, 0, 0);
        chk("t1_ready", 32'(packet_ready), 32'd1);
        chk("t1_pid", 32'(packet_pid), 32'h3);
        chk("t1_setup", 32'(packet_setup), 32'd1);
        chk("t1_endp", 32'(packet_endpoint), 32'd0);
        chk("t1_len", 32'(packet_length), 32'd8);
        for (int i = 0; i < 10; i++) chk("t1_buf", 32'(cap_mem[i]), 32'(setup_bytes[i+1]));

        // A second packet while the buffer is held is dropped and counted.
        pkt = '{8'h2D, 8'h00, 8'h10}; send_packet(0, 0, 0);
        pkt = setup_bytes; send_packet(0, 0, 0);
        chk("t3_ovf", 32'(overflow_count), 32'd1);
        chk("t3_len_held", 32'(packet_length), 32'd8);
        do_ack();
        chk("t3_ack", 32'(packet_ready), 32'd0);

        // A token with the wrong address makes the data packet be ignored.
        device_address = 7'd5;
        pkt = '{8'h2D, 8'h00, 8'h10}; send_packet(0, 0, 0);
        pkt = setup_bytes; send_packet(0, 0, 0);
        chk("t2_ready", 32'(packet_ready), 32'd0);
        chk("t2_ovf", 32'(overflow_count), 32'd1);
        do_ack();

        // OUT + DATA1. Then an ack in the same cycle as the next DATA PID.
        device_address = 7'h12;
        token_to(4'b0001, 7'h12, 4'd5);
        fill_pay(5, 3); build_data(4'b1011); send_packet(0, 0, 0);
        chk("t_out_len", 32'(packet_length), 32'd5);
        chk("t_out_pid", 32'(packet_pid), 32'hB);
        chk("t_out_endp", 32'(packet_endpoint), 32'd5);
        chk("t_out_setup", 32'(packet_setup), 32'd0);
        token_to(4'b0001, 7'h12, 4'd6);
        fill_pay(4, 8); build_data(4'b0011); send_packet(0, 0, 1);
        chk("t_ackpid_ovf", 32'(overflow_count), 32'd2);
        chk("t_ackpid_ready", 32'(packet_ready), 32'd0);

        // A bad CRC is dropped silently. The next DATA0 has no token.
        token_to(4'b1101, 7'h12, 4'd2);
        pkt = setup_bytes; pkt[10] = 8'h95; send_packet(0, 0, 0);
        chk("t4_ready", 32'(packet_ready), 32'd0);
        pkt = setup_bytes; send_packet(0, 0, 0);
        chk("t4_notoken", 32'(packet_ready), 32'd0);

        // A bad PID is discarded and leaves token_match unchanged.
        token_to(4'b0001, 7'h12, 4'd9);
        pkt = '{8'h2C, 8'h11, 8'h22}; send_packet(0, 0, 0);
        fill_pay(3, 9); build_data(4'b0011); send_packet(0, 0, 0);
        chk("t5_ready", 32'(packet_ready), 32'd1);
        chk("t5_endp", 32'(packet_endpoint), 32'd9);
        do_ack();
        do_ack();

        // Another valid PID (ACK) clears the token match.
        token_to(4'b0001, 7'h12, 4'd1);
        pkt = '{8'hD2}; send_packet(0, 0, 0);
        fill_pay(3, 1); build_data(4'b0011); send_packet(0, 0, 0);

        // rx_error in the middle of DATA.
        token_to(4'b0001, 7'h12, 4'd1);
        pkt = '{8'hC3, 8'h11, 8'h22, 8'h33}; send_packet(1, 0, 0);
        fill_pay(3, 1); build_data(4'b0011); send_packet(0, 0, 0);
        chk("t6_ready", 32'(packet_ready), 32'd0);

        // Boundaries: empty payload, a DATA packet shorter than the CRC, and short and long tokens.
        token_to(4'b0001, 7'h12, 4'd3);
        fill_pay(0, 0); build_data(4'b1011); send_packet(0, 0, 0);
        chk("t_zero_len", 32'(packet_length), 32'd0);
        chk("t_zero_ready", 32'(packet_ready), 32'd1);
        do_ack();
        token_to(4'b0001, 7'h12, 4'd3);
        pkt = '{8'hC3, 8'h5A}; send_packet(0, 0, 0);
        build_token(4'b0001, 7'h12, 4'd3); void'(pkt.pop_back()); send_packet(0, 0, 0);
        fill_pay(2, 4); build_data(4'b0011); send_packet(0, 0, 0);
        build_token(4'b0001, 7'h12, 4'd3); pkt.push_back(8'h00); send_packet(0, 0, 0);
        fill_pay(2, 4); build_data(4'b0011); send_packet(0, 0, 0);

        // Largest payload that fits, then one byte too many.
        token_to(4'b0001, 7'h12, 4'd4);
        fill_pay(1022, 1); build_data(4'b0011); send_packet(0, 0, 0);
        chk("t_max_len", 32'(packet_length), 32'd1022);
        do_ack();
        token_to(4'b0001, 7'h12, 4'd4);
        fill_pay(1023, 2); build_data(4'b0011); send_packet(0, 0, 0);
        chk("t_over_ovf", 32'(overflow_count), 32'd3);

        // overflow_count saturates at 255.
        token_to(4'b0001, 7'h12, 4'd7);
        fill_pay(1, 5); build_data(4'b0011); send_packet(0, 0, 0);
        for (int i = 0; i < 256; i++) begin
            token_to(4'b0001, 7'h12, 4'd7);
            pkt = '{8'hC3, 8'h00, 8'h00}; send_packet(0, 0, 0);
        end
        chk("t_sat_ovf", 32'(overflow_count), 32'd255);
        do_ack();

        // reset_n pulsed low in the middle of DATA.
        token_to(4'b0001, 7'h12, 4'd2);
        pkt = '{8'hC3, 8'h11, 8'h22, 8'h33}; send_packet(0, 1, 0);
        chk("t7_ready", 32'(packet_ready), 32'd0);
        chk("t7_ovf", 32'(overflow_count), 32'd0);
        chk("t7_len", 32'(packet_length), 32'd0);
        fill_pay(2, 6); build_data(4'b0011); send_packet(0, 0, 0);
        chk("t7_notoken", 32'(packet_ready), 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
